// File: rtl/blockram_port_requester_pkg.sv
// ============================================================================
// Module  : blockram_port_requester_pkg
// Brief   : Shared constants and helpers for the blockram port requester.
// Revision: 1.0
// ============================================================================
`default_nettype none

package blockram_port_requester_pkg;

    localparam int BYTE_LEN_IN_BITS = 8;

    // Pointer width that stays legal for a single-entry buffer.
    function automatic int ptr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/blockram_response_fifo.sv
// ============================================================================
// Module  : blockram_response_fifo
// Brief   : Small register-based FIFO with combinational head, modulo-DEPTH pointers.
// Revision: 1.0
// ============================================================================
`default_nettype none

module blockram_response_fifo
    import blockram_port_requester_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = 64
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         i_push,
    input  logic [WIDTH-1:0]             i_push_data,
    input  logic                         i_pop,
    output logic [WIDTH-1:0]             o_head,
    output logic                         o_full,
    output logic                         o_empty,
    output logic [$clog2(DEPTH+1)-1:0]   o_count
);

    localparam int c_PTR_W = ptr_width(DEPTH);
    localparam int c_CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_CNT_W-1:0] r_count;

    logic w_do_pop;
    logic w_do_push;

    function automatic logic [c_PTR_W-1:0] next_ptr(input logic [c_PTR_W-1:0] ptr);
        return (ptr == c_PTR_W'(DEPTH - 1)) ? '0 : ptr + 1'b1;
    endfunction

    // A pop frees the head slot in the same cycle, so push+pop at full is accepted.
    assign w_do_pop  = i_pop && (r_count != '0);
    assign w_do_push = i_push && ((r_count != c_CNT_W'(DEPTH)) || w_do_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_mem[r_wr_ptr] <= i_push_data;
                r_wr_ptr        <= next_ptr(r_wr_ptr);
            end
            if (w_do_pop) begin
                r_rd_ptr <= next_ptr(r_rd_ptr);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_head  = r_mem[r_rd_ptr];
    assign o_full  = (r_count == c_CNT_W'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_count = r_count;

endmodule

`default_nettype wire

// File: rtl/blockram_port_requester.sv
// ============================================================================
// Module  : blockram_port_requester
// Brief   : Client-side requester for one blockram port with credit-gated read buffering.
// Revision: 1.0
// ============================================================================
`default_nettype none

module blockram_port_requester
    import blockram_port_requester_pkg::*;
#(
    parameter int SINGLE_ENTRY_SIZE_IN_BITS = 64,
    parameter int NUM_SET                   = 64,
    parameter int SET_PTR_WIDTH_IN_BITS     = $clog2(NUM_SET),
    parameter int WRITE_MASK_LEN            = SINGLE_ENTRY_SIZE_IN_BITS / BYTE_LEN_IN_BITS,
    parameter int RAM_READ_LATENCY          = 2,
    parameter int RESP_DEPTH                = 4
) (
    input  logic                                 clk_in,
    input  logic                                 reset_n_in,
    input  logic                                 request_valid_in,
    output logic                                 request_ready_out,
    input  logic [WRITE_MASK_LEN-1:0]            request_write_en_in,
    input  logic [SET_PTR_WIDTH_IN_BITS-1:0]     request_set_addr_in,
    input  logic [SINGLE_ENTRY_SIZE_IN_BITS-1:0] request_write_entry_in,
    output logic                                 response_valid_out,
    input  logic                                 response_ready_in,
    output logic [SINGLE_ENTRY_SIZE_IN_BITS-1:0] response_entry_out,
    output logic                                 ram_access_en_out,
    output logic [WRITE_MASK_LEN-1:0]            ram_write_en_out,
    output logic [SET_PTR_WIDTH_IN_BITS-1:0]     ram_access_set_addr_out,
    output logic [SINGLE_ENTRY_SIZE_IN_BITS-1:0] ram_write_entry_out,
    input  logic [SINGLE_ENTRY_SIZE_IN_BITS-1:0] ram_read_entry_in,
    input  logic                                 ram_read_valid_in,
    output logic                                 protocol_error_out
);

    localparam int c_CNT_W = $clog2(RESP_DEPTH + 1);

    logic                                 r_live;
    logic                                 r_access_en;
    logic [WRITE_MASK_LEN-1:0]            r_write_en;
    logic [SET_PTR_WIDTH_IN_BITS-1:0]     r_set_addr;
    logic [SINGLE_ENTRY_SIZE_IN_BITS-1:0] r_write_entry;
    logic [RAM_READ_LATENCY-1:0]          r_rd_pipe;
    logic [c_CNT_W-1:0]                   r_outstanding;
    logic                                 r_protocol_error;

    logic                                 w_accept;
    logic                                 w_accept_read;
    logic                                 w_issue_read;
    logic                                 w_push;
    logic                                 w_pop;
    logic                                 w_fifo_full;
    logic                                 w_fifo_empty;
    logic [c_CNT_W-1:0]                   w_fifo_count;
    logic                                 w_unused_fifo_flags;

    // Outstanding counts reads from accept until their response is popped, which
    // equals in-flight plus buffered; it never exceeds the buffer depth.
    assign request_ready_out  = r_live && (r_outstanding < c_CNT_W'(RESP_DEPTH));
    assign w_accept           = request_valid_in && request_ready_out;
    assign w_accept_read      = w_accept && (request_write_en_in == '0);
    assign w_issue_read       = r_access_en && (r_write_en == '0);
    assign w_push             = r_rd_pipe[RAM_READ_LATENCY-1];
    assign response_valid_out = (w_fifo_count != '0);
    assign w_pop              = response_valid_out && response_ready_in;

    always_ff @(posedge clk_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            r_live        <= 1'b0;
            r_access_en   <= 1'b0;
            r_write_en    <= '0;
            r_set_addr    <= '0;
            r_write_entry <= '0;
        end else begin
            r_live <= 1'b1;
            if (w_accept) begin
                r_access_en   <= 1'b1;
                r_write_en    <= request_write_en_in;
                r_set_addr    <= request_set_addr_in;
                r_write_entry <= request_write_entry_in;
            end else begin
                r_access_en   <= 1'b0;
                r_write_en    <= '0;
                r_set_addr    <= '0;
                r_write_entry <= '0;
            end
        end
    end

    // Read tags track RAM latency; the last stage marks the cycle data is valid.
    always_ff @(posedge clk_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            r_rd_pipe <= '0;
        end else begin
            r_rd_pipe[0] <= w_issue_read;
            for (int i = 1; i < RAM_READ_LATENCY; i++) begin
                r_rd_pipe[i] <= r_rd_pipe[i-1];
            end
        end
    end

    always_ff @(posedge clk_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            r_outstanding <= '0;
        end else begin
            case ({w_accept_read, w_pop})
                2'b10:   r_outstanding <= r_outstanding + 1'b1;
                2'b01:   r_outstanding <= r_outstanding - 1'b1;
                default: r_outstanding <= r_outstanding;
            endcase
        end
    end

    always_ff @(posedge clk_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            r_protocol_error <= 1'b0;
        end else if (w_push && !ram_read_valid_in) begin
            r_protocol_error <= 1'b1;
        end
    end

    blockram_response_fifo #(
        .DEPTH (RESP_DEPTH),
        .WIDTH (SINGLE_ENTRY_SIZE_IN_BITS)
    ) u_resp_fifo (
        .clk         (clk_in),
        .rst_n       (reset_n_in),
        .i_push      (w_push),
        .i_push_data (ram_read_entry_in),
        .i_pop       (w_pop),
        .o_head      (response_entry_out),
        .o_full      (w_fifo_full),
        .o_empty     (w_fifo_empty),
        .o_count     (w_fifo_count)
    );

    // Credit gating makes the full/empty flags redundant here.
    assign w_unused_fifo_flags = w_fifo_full ^ w_fifo_empty;

    assign ram_access_en_out       = r_access_en;
    assign ram_write_en_out        = r_write_en;
    assign ram_access_set_addr_out = r_set_addr;
    assign ram_write_entry_out     = r_write_entry;
    assign protocol_error_out      = r_protocol_error;

endmodule

`default_nettype wire

// File: tb/tb_blockram_port_requester.sv
// ============================================================================
// Module  : tb_blockram_port_requester
// Brief   : Directed bench with a behavioural 64x64 latency-2 blockram port.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_blockram_port_requester;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        request_valid;
    logic        request_ready;
    logic [7:0]  request_write_en;
    logic [5:0]  request_set_addr;
    logic [63:0] request_write_entry;
    logic        response_valid;
    logic        response_ready;
    logic [63:0] response_entry;
    logic        ram_access_en;
    logic [7:0]  ram_write_en;
    logic [5:0]  ram_set_addr;
    logic [63:0] ram_write_entry;
    logic [63:0] ram_read_entry;
    logic        ram_read_valid;
    logic        protocol_error;

    logic        preload;
    logic        force_invalid;
    logic [63:0] mem [64];
    logic [63:0] s1_data;
    logic [63:0] s2_data;
    logic        s1_valid;
    logic        s2_valid;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    blockram_port_requester dut (
        .clk_in                  (clk),
        .reset_n_in              (reset_n),
        .request_valid_in        (request_valid),
        .request_ready_out       (request_ready),
        .request_write_en_in     (request_write_en),
        .request_set_addr_in     (request_set_addr),
        .request_write_entry_in  (request_write_entry),
        .response_valid_out      (response_valid),
        .response_ready_in       (response_ready),
        .response_entry_out      (response_entry),
        .ram_access_en_out       (ram_access_en),
        .ram_write_en_out        (ram_write_en),
        .ram_access_set_addr_out (ram_set_addr),
        .ram_write_entry_out     (ram_write_entry),
        .ram_read_entry_in       (ram_read_entry),
        .ram_read_valid_in       (ram_read_valid),
        .protocol_error_out      (protocol_error)
    );

    // Behavioural blockram port: byte-masked write, two-cycle registered read.
    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < 64; i++) mem[i] <= 64'(i);
            s1_valid <= 1'b0;
        end else if (ram_access_en) begin
            for (int b = 0; b < 8; b++) begin
                if (ram_write_en[b]) mem[ram_set_addr][8*b +: 8] <= ram_write_entry[8*b +: 8];
            end
            s1_valid <= (ram_write_en == 8'h00);
            s1_data  <= mem[ram_set_addr];
        end else begin
            s1_valid <= 1'b0;
        end
        s2_valid <= s1_valid;
        s2_data  <= s1_data;
    end

    assign ram_read_entry = s2_data;
    assign ram_read_valid = s2_valid && !force_invalid;

    typedef struct {
        logic [7:0]  mask;
        logic [5:0]  set;
        logic [63:0] wdata;
        logic [63:0] exp;
    } vec_t;

    vec_t vecs [9];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Entered at a negedge; returns at the negedge after the accepting edge.
    task automatic send(input logic [7:0] mask, input logic [5:0] set, input logic [63:0] wdata);
        int n;
        request_valid       = 1'b1;
        request_write_en    = mask;
        request_set_addr    = set;
        request_write_entry = wdata;
        n = 0;
        while (!request_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n == 50) check("send_timeout", 64'(request_ready), 64'd1);
        @(negedge clk);
        request_valid = 1'b0;
    endtask

    task automatic get_resp(input string name, input logic [63:0] exp);
        int n;
        response_ready = 1'b1;
        n = 0;
        while (!response_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        check({name, "_valid"}, 64'(response_valid), 64'd1);
        check({name, "_data"}, response_entry, exp);
        @(negedge clk);
        response_ready = 1'b0;
        check({name, "_drained"}, 64'(response_valid), 64'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{8'hFF, 6'd63, 64'hAAAA_AAAA_AAAA_AAAA, 64'h0};
        vecs[1] = '{8'h00, 6'd63, 64'h0, 64'hAAAA_AAAA_AAAA_AAAA};
        vecs[2] = '{8'hFF, 6'd45, 64'h0, 64'h0};
        vecs[3] = '{8'h0F, 6'd45, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0};
        vecs[4] = '{8'h00, 6'd45, 64'h0, 64'h0000_0000_FFFF_FFFF};
        vecs[5] = '{8'hF0, 6'd20, 64'h1234_5678_9ABC_DEF0, 64'h0};
        vecs[6] = '{8'h00, 6'd20, 64'h0, 64'h1234_5678_0000_0014};
        vecs[7] = '{8'h81, 6'd0, 64'hDDCC_BBAA_9988_77EE, 64'h0};
        vecs[8] = '{8'h00, 6'd0, 64'h0, 64'hDD00_0000_0000_00EE};

        reset_n             = 1'b0;
        request_valid       = 1'b0;
        request_write_en    = '0;
        request_set_addr    = '0;
        request_write_entry = '0;
        response_ready      = 1'b0;
        force_invalid       = 1'b0;
        preload             = 1'b1;

        repeat (3) @(negedge clk);
        preload = 1'b0;
        check("rst_access_en", 64'(ram_access_en), 64'd0);
        check("rst_write_en", 64'(ram_write_en), 64'd0);
        check("rst_set_addr", 64'(ram_set_addr), 64'd0);
        check("rst_write_entry", ram_write_entry, 64'd0);
        check("rst_resp_valid", 64'(response_valid), 64'd0);
        check("rst_resp_entry", response_entry, 64'd0);
        check("rst_error", 64'(protocol_error), 64'd0);
        check("rst_ready", 64'(request_ready), 64'd0);
        reset_n = 1'b1;
        @(negedge clk);
        check("ready_after_release", 64'(request_ready), 64'd1);

        for (int i = 0; i < 9; i++) begin
            send(vecs[i].mask, vecs[i].set, vecs[i].wdata);
            if (vecs[i].mask == 8'h00) get_resp($sformatf("vec%0d", i), vecs[i].exp);
        end
        check("table_error", 64'(protocol_error), 64'd0);

        // Eight back-to-back reads with the client stalled.
        preload = 1'b1;
        @(negedge clk);
        preload = 1'b0;
        begin
            int accepts;
            accepts = 0;
            fork
                begin
                    for (int i = 0; i < 8; i++) begin
                        int n;
                        request_valid    = 1'b1;
                        request_write_en = 8'h00;
                        request_set_addr = 6'(i);
                        n = 0;
                        while (!request_ready && n < 300) begin
                            @(negedge clk);
                            n++;
                        end
                        @(negedge clk);
                        accepts++;
                    end
                    request_valid = 1'b0;
                end
                begin
                    int k;
                    int cyc;
                    repeat (10) @(negedge clk);
                    check("b2b_accepts_stalled", 64'(accepts), 64'd4);
                    check("b2b_ready_stalled", 64'(request_ready), 64'd0);
                    response_ready = 1'b1;
                    k = 0;
                    cyc = 0;
                    while (k < 8 && cyc < 300) begin
                        if (response_valid) begin
                            check($sformatf("b2b_resp%0d", k), response_entry, 64'(k));
                            k++;
                        end
                        @(negedge clk);
                        cyc++;
                    end
                    check("b2b_resp_count", 64'(k), 64'd8);
                end
            join
        end
        repeat (5) @(negedge clk);
        check("b2b_no_extra", 64'(response_valid), 64'd0);
        response_ready = 1'b0;

        // RAM drops valid on one read.
        force_invalid = 1'b1;
        send(8'h00, 6'd7, 64'h0);
        get_resp("badvalid", 64'd7);
        force_invalid = 1'b0;
        check("error_set", 64'(protocol_error), 64'd1);
        send(8'h00, 6'd3, 64'h0);
        get_resp("after_err", 64'd3);
        check("error_sticky", 64'(protocol_error), 64'd1);

        // Reset with two reads in flight.
        send(8'h00, 6'd1, 64'h0);
        send(8'h00, 6'd2, 64'h0);
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        check("midrst_error", 64'(protocol_error), 64'd0);
        check("midrst_ready", 64'(request_ready), 64'd0);
        reset_n = 1'b1;
        response_ready = 1'b1;
        begin
            int seen;
            seen = 0;
            for (int c = 0; c < 10; c++) begin
                @(negedge clk);
                if (response_valid) seen++;
            end
            check("midrst_no_resp", 64'(seen), 64'd0);
        end
        check("midrst_ready_after", 64'(request_ready), 64'd1);
        check("midrst_error_after", 64'(protocol_error), 64'd0);
        response_ready = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
